// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - multi-cycle control sequencer for the 16-bit datapath.
// Define CTRL_AND_OP_EN to decode opcode 100 as "and Rx,Ry".
module proc_control_unit #(
  parameter int DIN_W  = 16,
  parameter int IR_LSB = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [DIN_W-1:0] din,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic             ir_in,
  output logic [3:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
`ifdef CTRL_AND_OP_EN
  localparam logic [2:0] OP_AND = 3'b100;
`endif

  state_t     state_q, state_d;
  logic [8:0] ir_q;
  logic [2:0] op, rx, ry;
  logic       is_alu;
  logic       din_unused;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Only the 9-bit instruction field is used; the rest of din feeds the datapath directly.
  assign din_unused = ^din;

`ifdef CTRL_AND_OP_EN
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`else
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && run)
        ir_q <= din[IR_LSB +: 9];
    end
  end

  always_comb begin
    state_d = state_q;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    ir_in   = 1'b0;
    bus_sel = 4'd0;
    alu_op  = 2'b00;
    done    = 1'b0;
    case (state_q)
      T0: begin
        // Gated by resetn so the fetch strobe stays low while reset holds state at T0.
        if (run) begin
          ir_in   = resetn;
          state_d = T1;
        end
      end
      T1: begin
        if (op == OP_MV) begin
          bus_sel = {1'b0, ry};
          r_in    = 8'd1 << rx;
          done    = 1'b1;
          state_d = T0;
        end else if (op == OP_MVI) begin
          bus_sel = 4'd9;
          r_in    = 8'd1 << rx;
          done    = 1'b1;
          state_d = T0;
        end else if (is_alu) begin
          bus_sel = {1'b0, rx};
          a_in    = 1'b1;
          state_d = T2;
        end else begin
          done    = 1'b1;
          state_d = T0;
        end
      end
      T2: begin
        bus_sel = {1'b0, ry};
        g_in    = 1'b1;
        if (op == OP_SUB)
          alu_op = 2'b01;
`ifdef CTRL_AND_OP_EN
        if (op == OP_AND)
          alu_op = 2'b10;
`endif
        state_d = T3;
      end
      T3: begin
        bus_sel = 4'd8;
        r_in    = 8'd1 << rx;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign busy = (state_q != T0);

endmodule

// File: tb/tb_proc_control_unit.sv
// tb/tb_proc_control_unit.sv - table-driven scoreboard bench for proc_control_unit.
module tb_proc_control_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [7:0]  r_in;
  logic        a_in, g_in, ir_in, done, busy;
  logic [3:0]  bus_sel;
  logic [1:0]  alu_op;

  always #5 clock = ~clock;

  proc_control_unit #(.DIN_W(16), .IR_LSB(0)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .ir_in   (ir_in),
    .bus_sel (bus_sel),
    .alu_op  (alu_op),
    .done    (done),
    .busy    (busy)
  );

  typedef struct {
    logic        rstn;
    logic        run;
    logic [15:0] din;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        ir_in;
    logic [3:0]  bus_sel;
    logic [1:0]  alu_op;
    logic        done;
    logic        busy;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] sb[$];
  string       sb_name[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Packed output word: {r_in, a_in, g_in, ir_in, bus_sel, alu_op, done, busy}
  function automatic logic [18:0] pk(logic [7:0] r, logic a, logic g, logic ir,
                                     logic [3:0] bs, logic [1:0] alu, logic d, logic b);
    return {r, a, g, ir, bs, alu, d, b};
  endfunction

  function automatic logic [18:0] dut_out();
    return pk(r_in, a_in, g_in, ir_in, bus_sel, alu_op, done, busy);
  endfunction

  task automatic addv(string nm, logic rs, logic rn, logic [15:0] d, logic [7:0] r, logic a,
                      logic g, logic ir, logic [3:0] bs, logic [1:0] alu, logic dn, logic b);
    vec_t v;
    v.name = nm; v.rstn = rs; v.run = rn; v.din = d; v.r_in = r; v.a_in = a; v.g_in = g;
    v.ir_in = ir; v.bus_sel = bs; v.alu_op = alu; v.done = dn; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, logic [18:0] act, logic [18:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {r_in,a,g,ir,bus,alu,done,busy}=%h required %h", nm, act, exp);
    end
  endtask

  initial begin
    // Reset held with run high, then idle.
    addv("rst0", 0, 1, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    addv("rst1", 0, 1, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++)
      addv("idle", 1, 0, 16'h0048, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    // mvi R1,#1234
    addv("mvi1_t0", 1, 1, 16'h0048, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("mvi1_t1", 1, 0, 16'h1234, 8'h02, 0, 0, 0, 4'd9, 2'b00, 1, 1);
    addv("mvi1_end", 1, 0, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    // 0x0043 decodes as mvi R0 (X = 0)
    addv("mvi0_t0", 1, 1, 16'h0043, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("mvi0_t1", 1, 0, 16'h1234, 8'h01, 0, 0, 0, 4'd9, 2'b00, 1, 1);
    // mv R0,R3
    addv("mv_t0", 1, 1, 16'h0003, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("mv_t1", 1, 0, 16'h0003, 8'h01, 0, 0, 0, 4'd3, 2'b00, 1, 1);
    addv("mv_end", 1, 0, 16'h0003, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    // sub R2,R1 with run held high, then immediate fetch of mv R0,R3
    addv("sub_t0", 1, 1, 16'h00D1, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("sub_t1", 1, 1, 16'h00D1, 8'h00, 1, 0, 0, 4'd2, 2'b00, 0, 1);
    addv("sub_t2", 1, 1, 16'h00D1, 8'h00, 0, 1, 0, 4'd1, 2'b01, 0, 1);
    addv("sub_t3", 1, 1, 16'h00D1, 8'h04, 0, 0, 0, 4'd8, 2'b00, 1, 1);
    addv("next_t0", 1, 1, 16'h0003, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("next_t1", 1, 0, 16'h0003, 8'h01, 0, 0, 0, 4'd3, 2'b00, 1, 1);
    // add R5,R5 to completion
    addv("add_t0", 1, 1, 16'h00AD, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("add_t1", 1, 0, 16'h0000, 8'h00, 1, 0, 0, 4'd5, 2'b00, 0, 1);
    addv("add_t2", 1, 0, 16'h0000, 8'h00, 0, 1, 0, 4'd5, 2'b00, 0, 1);
    addv("add_t3", 1, 0, 16'h0000, 8'h20, 0, 0, 0, 4'd8, 2'b00, 1, 1);
    // opcode 100
    addv("op4_t0", 1, 1, 16'h0111, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
`ifdef CTRL_AND_OP_EN
    addv("and_t1", 1, 0, 16'h0000, 8'h00, 1, 0, 0, 4'd2, 2'b00, 0, 1);
    addv("and_t2", 1, 0, 16'h0000, 8'h00, 0, 1, 0, 4'd1, 2'b10, 0, 1);
    addv("and_t3", 1, 0, 16'h0000, 8'h04, 0, 0, 0, 4'd8, 2'b00, 1, 1);
`else
    addv("op4_nop", 1, 0, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 1, 1);
`endif
    addv("op4_end", 1, 0, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);
    // opcode 111 NOP
    addv("nop7_t0", 1, 1, 16'h01FF, 8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    addv("nop7_t1", 1, 0, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 1, 1);
    addv("nop7_end", 1, 0, 16'h0000, 8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      resetn = vecs[i].rstn;
      run    = vecs[i].run;
      din    = vecs[i].din;
      sb.push_back(pk(vecs[i].r_in, vecs[i].a_in, vecs[i].g_in, vecs[i].ir_in,
                      vecs[i].bus_sel, vecs[i].alu_op, vecs[i].done, vecs[i].busy));
      sb_name.push_back($sformatf("%s[%0d]", vecs[i].name, i));
      @(negedge clock);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries required 1");
      end else begin
        check(sb_name.pop_front(), dut_out(), sb.pop_front());
      end
    end

    // add R5,R5 aborted by an asynchronous reset in T2
    @(posedge clock); #1; run = 1; din = 16'h00AD;
    @(negedge clock); check("abort_t0", dut_out(), pk(8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0));
    @(posedge clock); #1; run = 0; din = 16'h0000;
    @(negedge clock); check("abort_t1", dut_out(), pk(8'h00, 1, 0, 0, 4'd5, 2'b00, 0, 1));
    @(posedge clock); #1;
    check("abort_t2", dut_out(), pk(8'h00, 0, 1, 0, 4'd5, 2'b00, 0, 1));
    resetn = 0; run = 1;
    #1;
    check("abort_async", dut_out(), pk(8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0));
    @(posedge clock); #1;
    check("abort_hold", dut_out(), pk(8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0));
    resetn = 1; run = 0;
    @(negedge clock); check("abort_rel0", dut_out(), pk(8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0));
    @(posedge clock); #1;
    @(negedge clock); check("abort_rel1", dut_out(), pk(8'h00, 0, 0, 0, 4'd0, 2'b00, 0, 0));
    // IR was cleared by reset: a fresh fetch of mv R0,R3 behaves normally
    @(posedge clock); #1; run = 1; din = 16'h0003;
    @(negedge clock); check("post_t0", dut_out(), pk(8'h00, 0, 0, 1, 4'd0, 2'b00, 0, 0));
    @(posedge clock); #1; run = 0;
    @(negedge clock); check("post_t1", dut_out(), pk(8'h01, 0, 0, 0, 4'd3, 2'b00, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
